// File: rtl/mem_arbiter2_pkg.sv
// Shared definitions for the two-master picorv32 native-memory arbiter.
// State encodings, one-hot grant constants and the request-field bundle live here.
package mem_arbiter2_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEADBEEF;

    typedef struct packed {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_req_t;

    // The grant output doubles as the externally visible FSM state.
    function automatic logic [1:0] state_to_grant(input logic [1:0] st);
        case (st)
            OWN0:    return GRANT_M0;
            OWN1:    return GRANT_M1;
            default: return GRANT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter2_mux.sv
// Owner-select mux for the slave request fields; outputs all-zero when nobody owns the port.
module mem_arbiter2_mux
    import mem_arbiter2_pkg::*;
(
    input  logic [1:0] grant,
    input  logic       m0_valid,
    input  mem_req_t   m0_req,
    input  logic       m1_valid,
    input  mem_req_t   m1_req,
    output logic       sel_valid,
    output mem_req_t   sel_req
);

    always_comb begin
        sel_valid = 1'b0;
        sel_req   = '0;
        case (grant)
            GRANT_M0: begin
                sel_valid = m0_valid;
                sel_req   = m0_req;
            end
            GRANT_M1: begin
                sel_valid = m1_valid;
                sel_req   = m1_req;
            end
            default: begin
                sel_valid = 1'b0;
                sel_req   = '0;
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter2.sv
// Two-master round-robin arbiter for the picorv32 native memory interface.
// Define MEM_ARBITER_TIMEOUT_EN to force-complete transactions the slave never answers.
module mem_arbiter2
    import mem_arbiter2_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant,
    output logic        timeout_pulse
);

    // Handshake: a master holds valid and its fields stable until it sees ready for
    // one cycle; ready is combinational from the slave, so completion costs no cycle.
    logic [1:0] state_q, state_d;
    logic       rr_last_q, rr_last_d;
    logic       own0, own1, sel_valid, complete, timeout;
    mem_req_t   m0_req, m1_req, sel_req;

    assign m0_req = '{instr: m0_instr, addr: m0_addr, wdata: m0_wdata, wstrb: m0_wstrb};
    assign m1_req = '{instr: m1_instr, addr: m1_addr, wdata: m1_wdata, wstrb: m1_wstrb};

    assign own0  = (state_q == OWN0);
    assign own1  = (state_q == OWN1);
    assign grant = state_to_grant(state_q);

    mem_arbiter2_mux u_mux (
        .grant     (grant),
        .m0_valid  (m0_valid),
        .m0_req    (m0_req),
        .m1_valid  (m1_valid),
        .m1_req    (m1_req),
        .sel_valid (sel_valid),
        .sel_req   (sel_req)
    );

`ifdef MEM_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    // A real s_ready in the limit cycle wins over the forced completion.
    assign timeout = (own0 || own1) && sel_valid && !s_ready && (wait_cnt_q == CNT_MAX);

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_q == IDLE) begin
            wait_cnt_d = '0;
        end else if (sel_valid && !s_ready && (wait_cnt_q != CNT_MAX)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    logic [31:0] unused_cfg;

    assign timeout    = 1'b0;
    assign unused_cfg = ERR_RDATA ^ 32'(TIMEOUT_CYCLES);
`endif

    assign s_valid  = sel_valid && !timeout;
    assign s_instr  = sel_req.instr;
    assign s_addr   = sel_req.addr;
    assign s_wdata  = sel_req.wdata;
    assign s_wstrb  = sel_req.wstrb;
    assign complete = s_valid && s_ready;

    assign m0_ready      = own0 && (complete || timeout);
    assign m1_ready      = own1 && (complete || timeout);
    assign m0_rdata      = (own0 && timeout) ? ERR_RDATA : s_rdata;
    assign m1_rdata      = (own1 && timeout) ? ERR_RDATA : s_rdata;
    assign timeout_pulse = timeout;

    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        case (state_q)
            IDLE: begin
                if (m0_valid && m1_valid) begin
                    state_d = rr_last_q ? OWN0 : OWN1;
                end else if (m0_valid) begin
                    state_d = OWN0;
                end else if (m1_valid) begin
                    state_d = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (complete || timeout) begin
                    state_d   = IDLE;
                    rr_last_d = own1;
                end else if (!sel_valid) begin
                    // Owner abandoned the request: release without touching fairness.
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            rr_last_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
        end
    end

endmodule

// File: doc/mem_arbiter2.md
Name: mem_arbiter2

Overview:
- Two-master, one-slave arbiter for the picorv32 native memory interface (valid/ready/instr/addr/wdata/wstrb/rdata).
- Lets a second requester (DMA or debug port) share the core's single memory port.
- Sits between the masters and the memory/bus model used by the core and its formal benches.
- Round-robin fairness; a grant is held for the whole transaction.

Parameters:
- TIMEOUT_CYCLES, 255, slave-wait cycles before forced completion (used only with the optional feature); must be >= 1.
- ERR_RDATA, 32'hDEADBEEF, rdata returned on a timed-out transaction (optional feature only).

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- m0_valid  in  1  master 0 request
- m0_instr  in  1  master 0 instruction-fetch flag
- m0_addr  in  32  master 0 address
- m0_wdata  in  32  master 0 write data
- m0_wstrb  in  4  master 0 byte strobes (0 = read)
- m0_ready  out  1  master 0 completion
- m0_rdata  out  32  master 0 read data
- m1_valid, m1_instr, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata: same as m0_*, for master 1
- s_valid  out  1  slave request
- s_instr  out  1  slave instruction-fetch flag
- s_addr  out  32  slave address
- s_wdata  out  32  slave write data
- s_wstrb  out  4  slave byte strobes
- s_ready  in  1  slave completion
- s_rdata  in  32  slave read data
- grant  out  2  one-hot current owner; 00 = idle
- timeout_pulse  out  1  one-cycle pulse on forced completion

Behaviour:
- Reset: state IDLE, grant=00, rr_last=1 (so m0 wins first), s_valid=0, m0_ready=m1_ready=0, timeout_pulse=0, wait counter=0.
- FSM states: IDLE, OWN0, OWN1.
- IDLE:
  - Only m0_valid: go to OWN0.
  - Only m1_valid: go to OWN1.
  - Both valid: grant the master != rr_last.
  - No slave outputs are asserted in IDLE. Arbitration costs exactly 1 cycle.
- OWNn, slave outputs:
  - s_valid = mn_valid.
  - s_instr/s_addr/s_wdata/s_wstrb = master n's signals, combinational pass-through.
  - Non-owner fields are muxed away; s_* fields are 0 when idle.
- OWNn, completion:
  - mn_ready = s_ready && s_valid, combinational, same cycle.
  - Non-owner ready is always 0.
  - s_rdata is forwarded to both mN_rdata; only ready qualifies it.
- Completion (s_valid && s_ready): next state IDLE, rr_last <= n. Back-to-back requests from the same master therefore see 1 idle cycle between transactions.
- Owner drops valid without ready (protocol violation or abort): return to IDLE; rr_last is unchanged.
- Non-owner request arriving mid-transaction: held pending, no ready, until the owner completes.
- Simultaneous completion and new requests: the new request is arbitrated on the following cycle, using the updated rr_last.
- Reset asserted mid-transaction: state, grant and outputs return to reset values next cycle; the in-flight slave access is abandoned.
- Without the optional feature, timeout_pulse is constant 0.

Optional Feature:
- Macro: MEM_ARBITER_TIMEOUT_EN.
- With the macro:
  - Wait counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to OWNn.
  - It increments each OWNn cycle where s_valid && !s_ready.
  - When it reaches TIMEOUT_CYCLES and s_ready is still 0: for one cycle, mn_ready=1, mn_rdata=ERR_RDATA, s_valid=0 and timeout_pulse=1.
  - The FSM then goes to IDLE and rr_last <= n.
  - A real s_ready in the same cycle as the timeout takes precedence: normal completion, no pulse.
- Without the macro: no counter; a transaction waits forever.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE/OWN0/OWN1;
  - the GRANT_NONE/GRANT_M0/GRANT_M1 one-hot constants;
  - the ERR_RDATA default constant.
- Optional sub-module mem_arbiter2_mux: a purely combinational owner-select mux for the s_* request fields, reusable if the design later grows to N masters.

Test Plan:
- Single m0 read, addr 32'h100, slave ready after 2 wait cycles with rdata 32'h12345678 -> grant=01 one cycle after valid; m0_ready high with m0_rdata=32'h12345678 in the ready cycle; m1_ready stays 0.
- m0 and m1 valid together out of reset -> m0 served first; m1 granted on the cycle after m0 completes plus the 1 arbitration cycle; a third simultaneous round grants m0 again.
- m1 write, addr 32'h200, wdata 32'hCAFEF00D, wstrb 4'b0011, while m0 is pending -> s_wstrb=0011 and s_wdata match exactly; m0 is not granted until m1_ready has pulsed.
- Owner drops m0_valid after 1 cycle without s_ready -> FSM returns to IDLE; rr_last is unchanged, so m0 wins the next contention.
- resetn low during OWN1 -> next cycle grant=00, s_valid=0, all ready outputs 0.
- With MEM_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=4, slave never ready -> after 4 waiting cycles m0_ready=1, m0_rdata=32'hDEADBEEF, timeout_pulse=1 for exactly one cycle. Same stimulus with s_ready rising in that cycle -> normal completion, no pulse.
